// File: rtl/clock_time_core_if.sv
// rtl/clock_time_core_if.sv - tick/button inputs and segment outputs of clock_time_core
//
// Signals:
//   tick_1hz       1-cycle pulse once per second
//   tick_blink     1-cycle pulse that toggles the blink phase
//   btn_mode       debounced pulse, advances the set-mode FSM
//   btn_up         debounced pulse, increments the selected field
//   seg_data_array 48-bit registered segment bytes, digit0 in [7:0]
//   set_active     registered, high while the FSM is in a set state
// master = stimulus source / consumer side, slave = clock_time_core.
interface clock_time_core_if;
    logic        tick_1hz;
    logic        tick_blink;
    logic        btn_mode;
    logic        btn_up;
    logic [47:0] seg_data_array;
    logic        set_active;

    modport master (
        output tick_1hz, tick_blink, btn_mode, btn_up,
        input  seg_data_array, set_active
    );

    modport slave (
        input  tick_1hz, tick_blink, btn_mode, btn_up,
        output seg_data_array, set_active
    );
endinterface

// File: rtl/clock_time_core.sv
// rtl/clock_time_core.sv - BCD HH:MM:SS keeper with set-mode FSM and 7-segment encoder
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  clock_time_core_if.slave: tick_1hz, tick_blink, btn_mode, btn_up in;
//        seg_data_array (digit5 = hours tens ... digit0 = seconds ones), set_active out
// Parameters: INIT_HOUR/INIT_MIN/INIT_SEC reset time (decimal), SEG_ACTIVE_LOW inverts
// every segment bit including blank and reset values.
module clock_time_core #(
    parameter int INIT_HOUR      = 12,
    parameter int INIT_MIN       = 0,
    parameter int INIT_SEC       = 0,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             rst,
    clock_time_core_if.slave bus
);
    localparam logic [3:0] INIT_HT = 4'(INIT_HOUR / 10);
    localparam logic [3:0] INIT_HO = 4'(INIT_HOUR % 10);
    localparam logic [3:0] INIT_MT = 4'(INIT_MIN / 10);
    localparam logic [3:0] INIT_MO = 4'(INIT_MIN % 10);
    localparam logic [3:0] INIT_ST = 4'(INIT_SEC / 10);
    localparam logic [3:0] INIT_SO = 4'(INIT_SEC % 10);
    localparam logic [47:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? {48{1'b1}} : 48'h0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  hr_t, hr_o, mn_t, mn_o, sc_t, sc_o;
    logic        blink;
    logic [47:0] seg_q;
    logic        set_active_q;

    // Returns {carry, tens, ones} for a 00..59 BCD field.
    function automatic logic [8:0] inc60(input logic [3:0] t, input logic [3:0] o);
        if (o != 4'd9) return {1'b0, t, o + 4'd1};
        if (t != 4'd5) return {1'b0, t + 4'd1, 4'd0};
        return {1'b1, 4'd0, 4'd0};
    endfunction

    // Returns {tens, ones} for a 00..23 BCD hour field.
    function automatic logic [7:0] inc24(input logic [3:0] t, input logic [3:0] o);
        if (t == 4'd2 && o == 4'd3) return 8'h00;
        if (o == 4'd9) return {t + 4'd1, 4'd0};
        return {t, o + 4'd1};
    endfunction

    // Segment byte {dp,g,f,e,d,c,b,a}, active-high.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    logic [8:0]       sec_inc, min_inc;
    logic [7:0]       hr_inc;
    logic [5:0][7:0]  dig;
    logic [47:0]      seg_next;

    assign sec_inc = inc60(sc_t, sc_o);
    assign min_inc = inc60(mn_t, mn_o);
    assign hr_inc  = inc24(hr_t, hr_o);

    always_comb begin
        dig[0] = seg7(sc_o);
        dig[1] = seg7(sc_t);
        dig[2] = seg7(mn_o) | 8'h80;
        dig[3] = seg7(mn_t);
        dig[4] = seg7(hr_o) | 8'h80;
        dig[5] = seg7(hr_t);
        if (blink) begin
            case (state)
                SET_H: begin dig[5] = 8'h00; dig[4] = 8'h00; end
                SET_M: begin dig[3] = 8'h00; dig[2] = 8'h00; end
                SET_S: begin dig[1] = 8'h00; dig[0] = 8'h00; end
                default: ;
            endcase
        end
        seg_next = dig ^ SEG_INV;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            hr_t         <= INIT_HT;
            hr_o         <= INIT_HO;
            mn_t         <= INIT_MT;
            mn_o         <= INIT_MO;
            sc_t         <= INIT_ST;
            sc_o         <= INIT_SO;
            blink        <= 1'b0;
            seg_q        <= SEG_INV;
            set_active_q <= 1'b0;
        end else begin
            seg_q        <= seg_next;
            set_active_q <= (state != RUN);

            // Any mode change restarts the blink so the new field shows at once.
            if (bus.btn_mode) begin
                blink <= 1'b0;
                case (state)
                    RUN:     state <= SET_H;
                    SET_H:   state <= SET_M;
                    SET_M:   state <= SET_S;
                    default: state <= RUN;
                endcase
            end else if (bus.tick_blink) begin
                blink <= ~blink;
            end

            // Time update uses the pre-transition state; btn_mode suppresses btn_up.
            case (state)
                RUN: begin
                    if (bus.tick_1hz) begin
                        {sc_t, sc_o} <= sec_inc[7:0];
                        if (sec_inc[8]) begin
                            {mn_t, mn_o} <= min_inc[7:0];
                            if (min_inc[8]) {hr_t, hr_o} <= hr_inc;
                        end
                    end
                end
                SET_H:   if (bus.btn_up && !bus.btn_mode) {hr_t, hr_o} <= hr_inc;
                SET_M:   if (bus.btn_up && !bus.btn_mode) {mn_t, mn_o} <= min_inc[7:0];
                default: if (bus.btn_up && !bus.btn_mode) {sc_t, sc_o} <= sec_inc[7:0];
            endcase
        end
    end

    assign bus.seg_data_array = seg_q;
    assign bus.set_active     = set_active_q;
endmodule

// File: tb/tb_clock_time_core.sv
// tb/tb_clock_time_core.sv - directed self-checking bench for clock_time_core
module tb_clock_time_core;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    clock_time_core_if bus0 ();
    clock_time_core_if bus1 ();
    clock_time_core_if bus2 ();

    clock_time_core #(.INIT_HOUR(12), .INIT_MIN(0), .INIT_SEC(0), .SEG_ACTIVE_LOW(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    clock_time_core #(.INIT_HOUR(23), .INIT_MIN(59), .INIT_SEC(59), .SEG_ACTIVE_LOW(0))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    clock_time_core #(.INIT_HOUR(12), .INIT_MIN(0), .INIT_SEC(0), .SEG_ACTIVE_LOW(1))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    localparam logic [47:0] T120000 = 48'h06DB3FBF3F3F;
    localparam logic [47:0] T235959 = 48'h5BCF6DEF6D6F;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // bus0 and bus2 always receive identical stimulus.
    task automatic drive(input logic t, input logic b, input logic m, input logic u);
        bus0.tick_1hz = t; bus0.tick_blink = b; bus0.btn_mode = m; bus0.btn_up = u;
        bus2.tick_1hz = t; bus2.tick_blink = b; bus2.btn_mode = m; bus2.btn_up = u;
    endtask

    task automatic pulse(input logic t, input logic b, input logic m, input logic u);
        drive(t, b, m, u);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        bus1.tick_1hz = 1'b0; bus1.tick_blink = 1'b0; bus1.btn_mode = 1'b0; bus1.btn_up = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus0.seg_data_array !== 48'h0) begin errors++; $display("FAIL reset_seg0 got %h want %h", bus0.seg_data_array, 48'h0); end
        checks++; if (bus0.set_active !== 1'b0) begin errors++; $display("FAIL reset_set_active got %b want 0", bus0.set_active); end
        checks++; if (bus2.seg_data_array !== 48'hFFFFFFFFFFFF) begin errors++; $display("FAIL reset_seg2 got %h want %h", bus2.seg_data_array, 48'hFFFFFFFFFFFF); end
        rst = 1'b0;
        step();
        checks++; if (bus0.seg_data_array !== T120000) begin errors++; $display("FAIL init_seg0 got %h want %h", bus0.seg_data_array, T120000); end
        checks++; if (bus1.seg_data_array !== T235959) begin errors++; $display("FAIL init_seg1 got %h want %h", bus1.seg_data_array, T235959); end
        checks++; if (bus2.seg_data_array !== ~T120000) begin errors++; $display("FAIL init_seg2 got %h want %h", bus2.seg_data_array, ~T120000); end
        checks++; if (bus0.set_active !== 1'b0) begin errors++; $display("FAIL init_set_active got %b want 0", bus0.set_active); end
    endtask

    task automatic test_run_wrap();
        bus1.tick_1hz = 1'b1;
        step();
        bus1.tick_1hz = 1'b0;
        step();
        checks++; if (bus1.seg_data_array !== 48'h3FBF3FBF3F3F) begin errors++; $display("FAIL day_wrap got %h want %h", bus1.seg_data_array, 48'h3FBF3FBF3F3F); end
        for (int i = 0; i < 9; i++) begin
            bus1.tick_1hz = 1'b1;
            step();
            bus1.tick_1hz = 1'b0;
        end
        step();
        checks++; if (bus1.seg_data_array[7:0] !== 8'h6F) begin errors++; $display("FAIL sec_ones_9 got %h want %h", bus1.seg_data_array[7:0], 8'h6F); end
        checks++; if (bus1.seg_data_array !== 48'h3FBF3FBF3F6F) begin errors++; $display("FAIL run_00_00_09 got %h want %h", bus1.seg_data_array, 48'h3FBF3FBF3F6F); end
    endtask

    task automatic test_set_hour();
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (bus0.set_active !== 1'b1) begin errors++; $display("FAIL set_h_active got %b want 1", bus0.set_active); end
        checks++; if (bus0.seg_data_array !== T120000) begin errors++; $display("FAIL set_h_entry got %h want %h", bus0.seg_data_array, T120000); end
        for (int i = 0; i < 11; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (bus0.seg_data_array !== 48'h5BCF3FBF3F3F) begin errors++; $display("FAIL hour_23 got %h want %h", bus0.seg_data_array, 48'h5BCF3FBF3F3F); end
        for (int i = 0; i < 2; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F863FBF3F3F) begin errors++; $display("FAIL hour_wrap_01 got %h want %h", bus0.seg_data_array, 48'h3F863FBF3F3F); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F863FBF3F3F) begin errors++; $display("FAIL set_h_frozen got %h want %h", bus0.seg_data_array, 48'h3F863FBF3F3F); end
        checks++; if (bus2.seg_data_array !== ~48'h3F863FBF3F3F) begin errors++; $display("FAIL set_h_inv got %h want %h", bus2.seg_data_array, ~48'h3F863FBF3F3F); end
    endtask

    task automatic test_simultaneous_set();
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F863FBF3F3F) begin errors++; $display("FAIL mode_beats_up got %h want %h", bus0.seg_data_array, 48'h3F863FBF3F3F); end
        for (int i = 0; i < 59; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F866DEF3F3F) begin errors++; $display("FAIL min_59 got %h want %h", bus0.seg_data_array, 48'h3F866DEF3F3F); end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F863FBF3F3F) begin errors++; $display("FAIL min_wrap got %h want %h", bus0.seg_data_array, 48'h3F863FBF3F3F); end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F863F863F3F) begin errors++; $display("FAIL min_01 got %h want %h", bus0.seg_data_array, 48'h3F863F863F3F); end
    endtask

    task automatic test_blink();
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F8600003F3F) begin errors++; $display("FAIL blink_min_off got %h want %h", bus0.seg_data_array, 48'h3F8600003F3F); end
        checks++; if (bus2.seg_data_array !== ~48'h3F8600003F3F) begin errors++; $display("FAIL blink_min_inv got %h want %h", bus2.seg_data_array, ~48'h3F8600003F3F); end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F863F863F3F) begin errors++; $display("FAIL blink_min_on got %h want %h", bus0.seg_data_array, 48'h3F863F863F3F); end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F8600003F3F) begin errors++; $display("FAIL blink_min_off2 got %h want %h", bus0.seg_data_array, 48'h3F8600003F3F); end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F863F863F3F) begin errors++; $display("FAIL blink_cleared got %h want %h", bus0.seg_data_array, 48'h3F863F863F3F); end
        for (int i = 0; i < 59; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F863F866D6F) begin errors++; $display("FAIL sec_59 got %h want %h", bus0.seg_data_array, 48'h3F863F866D6F); end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F863F863F3F) begin errors++; $display("FAIL sec_wrap got %h want %h", bus0.seg_data_array, 48'h3F863F863F3F); end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (bus0.seg_data_array !== 48'h3F863F860000) begin errors++; $display("FAIL blink_sec_off got %h want %h", bus0.seg_data_array, 48'h3F863F860000); end
        checks++; if (bus2.seg_data_array !== ~48'h3F863F860000) begin errors++; $display("FAIL blink_sec_inv got %h want %h", bus2.seg_data_array, ~48'h3F863F860000); end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus0.seg_data_array !== 48'h0) begin errors++; $display("FAIL async_seg0 got %h want %h", bus0.seg_data_array, 48'h0); end
        checks++; if (bus0.set_active !== 1'b0) begin errors++; $display("FAIL async_set_active got %b want 0", bus0.set_active); end
        checks++; if (bus2.seg_data_array !== 48'hFFFFFFFFFFFF) begin errors++; $display("FAIL async_seg2 got %h want %h", bus2.seg_data_array, 48'hFFFFFFFFFFFF); end
        #2;
        rst = 1'b0;
        step();
        checks++; if (bus0.seg_data_array !== T120000) begin errors++; $display("FAIL post_rst_seg0 got %h want %h", bus0.seg_data_array, T120000); end
        checks++; if (bus2.seg_data_array !== ~T120000) begin errors++; $display("FAIL post_rst_seg2 got %h want %h", bus2.seg_data_array, ~T120000); end
        checks++; if (bus1.seg_data_array !== T235959) begin errors++; $display("FAIL post_rst_seg1 got %h want %h", bus1.seg_data_array, T235959); end
        checks++; if (bus0.set_active !== 1'b0) begin errors++; $display("FAIL post_rst_set_active got %b want 0", bus0.set_active); end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (bus0.seg_data_array !== T120000) begin errors++; $display("FAIL run_ignores_up got %h want %h", bus0.seg_data_array, T120000); end
    endtask

    task automatic test_tick_and_mode();
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (bus0.seg_data_array !== 48'h06DB3FBF3F06) begin errors++; $display("FAIL tick_mode_time got %h want %h", bus0.seg_data_array, 48'h06DB3FBF3F06); end
        checks++; if (bus0.set_active !== 1'b1) begin errors++; $display("FAIL tick_mode_state got %b want 1", bus0.set_active); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_run_wrap();
        test_set_hour();
        test_simultaneous_set();
        test_blink();
        test_async_reset();
        test_tick_and_mode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
